// File: rtl/text_overlay_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay_scheduler_if
// Description : Slot-write handshake bundle for the text overlay scheduler.
//               The master drives a slot record plus cfg_valid; the slave
//               answers with cfg_ready. A write transfers when both are high.
// Revision    : 1.0 - initial release
// ============================================================================
interface text_overlay_scheduler_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_slot;
  logic [7:0] cfg_char;
  logic [9:0] cfg_x;
  logic [9:0] cfg_y;
  logic       cfg_en;

  modport master (
    output cfg_valid, cfg_slot, cfg_char, cfg_x, cfg_y, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_slot, cfg_char, cfg_x, cfg_y, cfg_en,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/text_overlay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay_scheduler
// Description : Double-buffered table of letter slots for a VGA text overlay.
//               Writes land in a pending table and are copied to the active
//               table once per frame, just after the first non-visible row
//               starts. The active table is hit-tested against the current
//               pixel through a two-stage pipeline (per-slot hit, then
//               lowest-index priority select).
// Revision    : 1.0 - initial release
// ============================================================================
module text_overlay_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int GLYPH_W   = 8,
  parameter int GLYPH_H   = 16,
  parameter int VF_PORCH  = 480
) (
  input  wire logic                       VGA_clk,
  input  wire logic                       reset_n,
  input  wire logic [9:0]                 xPixel,
  input  wire logic [9:0]                 yPixel,
  input  wire logic                       display_area,
  text_overlay_scheduler_if.slave         cfg,
  output logic                            glyph_valid,
  output logic [7:0]                      glyph_char,
  output logic [$clog2(GLYPH_H)-1:0]      glyph_row,
  output logic [$clog2(GLYPH_W)-1:0]      glyph_col,
  output logic [2:0]                      glyph_slot,
  output logic                            pix_active,
  output logic [7:0]                      frame_count
);

  localparam int c_row_w = $clog2(GLYPH_H);
  localparam int c_col_w = $clog2(GLYPH_W);

  typedef struct packed {
    logic [7:0] ch;
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } slot_t;

  // --------------------------------------------------------------------------
  // Slot tables and commit control
  // --------------------------------------------------------------------------
  slot_t                pend_q   [NUM_SLOTS];
  slot_t                pend_d   [NUM_SLOTS];
  slot_t                act_q    [NUM_SLOTS];
  slot_t                act_d    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] dirty_q, dirty_d;
  logic                 commit_q, commit_d;   // high during the copy cycle
  logic                 ready_q, ready_d;
  logic [7:0]           fc_q, fc_d;

  logic commit_pt;
  logic xfer;

  assign commit_pt     = (yPixel == 10'(VF_PORCH)) && (xPixel == 10'd0);
  assign cfg.cfg_ready = ready_q;
  assign xfer          = cfg.cfg_valid && ready_q;
  assign frame_count   = fc_q;

  // Table update: copy dirty slots on the commit cycle, then capture any write.
  // cfg_ready is low on the copy cycle, so the two never collide.
  always_comb begin
    pend_d   = pend_q;
    act_d    = act_q;
    dirty_d  = dirty_q;
    fc_d     = fc_q;
    commit_d = commit_pt;
    ready_d  = !commit_pt;
    if (commit_q) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (dirty_q[i]) begin
          act_d[i] = pend_q[i];
        end
      end
      dirty_d = '0;
      fc_d    = fc_q + 8'd1;
    end
    if (xfer) begin
      // Slot indices with no matching entry fall through: the write is
      // accepted but changes nothing.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cfg.cfg_slot == 3'(i)) begin
          pend_d[i]  = '{ch: cfg.cfg_char, x: cfg.cfg_x, y: cfg.cfg_y, en: cfg.cfg_en};
          dirty_d[i] = 1'b1;
        end
      end
    end
  end

  // Table and commit-control registers.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
      dirty_q  <= '0;
      commit_q <= 1'b0;
      ready_q  <= 1'b0;
      fc_q     <= 8'd0;
    end else begin
      pend_q   <= pend_d;
      act_q    <= act_d;
      dirty_q  <= dirty_d;
      commit_q <= commit_d;
      ready_q  <= ready_d;
      fc_q     <= fc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: per-slot hit test and in-glyph offsets
  // --------------------------------------------------------------------------
  logic [10:0]          dx [NUM_SLOTS];
  logic [10:0]          dy [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] s1_hit_q, s1_hit_d;
  logic [c_row_w-1:0]   s1_row_q  [NUM_SLOTS];
  logic [c_row_w-1:0]   s1_row_d  [NUM_SLOTS];
  logic [c_col_w-1:0]   s1_col_q  [NUM_SLOTS];
  logic [c_col_w-1:0]   s1_col_d  [NUM_SLOTS];
  logic [7:0]           s1_char_q [NUM_SLOTS];
  logic [7:0]           s1_char_d [NUM_SLOTS];
  logic                 s1_disp_q, s1_disp_d;

  // Offsets are taken in 11 bits: a pixel left of / above a glyph yields a
  // huge unsigned value instead of wrapping into the glyph near column 1023.
  always_comb begin
    s1_disp_d = display_area;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dx[i]        = {1'b0, xPixel} - {1'b0, act_q[i].x};
      dy[i]        = {1'b0, yPixel} - {1'b0, act_q[i].y};
      s1_hit_d[i]  = act_q[i].en && (dx[i] < 11'(GLYPH_W)) && (dy[i] < 11'(GLYPH_H));
      s1_col_d[i]  = dx[i][c_col_w-1:0];
      s1_row_d[i]  = dy[i][c_row_w-1:0];
      s1_char_d[i] = act_q[i].ch;
    end
  end

  // Stage-1 pipeline registers.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hit_q  <= '0;
      s1_disp_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        s1_row_q[i]  <= '0;
        s1_col_q[i]  <= '0;
        s1_char_q[i] <= '0;
      end
    end else begin
      s1_hit_q  <= s1_hit_d;
      s1_disp_q <= s1_disp_d;
      s1_row_q  <= s1_row_d;
      s1_col_q  <= s1_col_d;
      s1_char_q <= s1_char_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: priority select (lowest slot index wins)
  // --------------------------------------------------------------------------
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_char_q,  out_char_d;
  logic [c_row_w-1:0] out_row_q,   out_row_d;
  logic [c_col_w-1:0] out_col_q,   out_col_d;
  logic [2:0]         out_slot_q,  out_slot_d;
  logic               out_pix_q,   out_pix_d;

  // Scanning from the top index down lets the lowest hitting slot overwrite
  // the others; fields stay zero when nothing is drawn.
  always_comb begin
    out_valid_d = 1'b0;
    out_char_d  = '0;
    out_row_d   = '0;
    out_col_d   = '0;
    out_slot_d  = '0;
    out_pix_d   = s1_disp_q;
    if (s1_disp_q) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (s1_hit_q[i]) begin
          out_valid_d = 1'b1;
          out_char_d  = s1_char_q[i];
          out_row_d   = s1_row_q[i];
          out_col_d   = s1_col_q[i];
          out_slot_d  = 3'(i);
        end
      end
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_slot_q  <= '0;
      out_pix_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_slot_q  <= out_slot_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign glyph_valid = out_valid_q;
  assign glyph_char  = out_char_q;
  assign glyph_row   = out_row_q;
  assign glyph_col   = out_col_q;
  assign glyph_slot  = out_slot_q;
  assign pix_active  = out_pix_q;

endmodule
`default_nettype wire

// File: tb/tb_text_overlay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_overlay_scheduler
// Description : Self-checking bench for text_overlay_scheduler. Each pixel
//               driven with a tag gets an expected record queued; the record
//               observed two cycles later is captured and compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_overlay_scheduler;

  localparam int NUM_SLOTS = 4;
  localparam int GLYPH_W   = 8;
  localparam int GLYPH_H   = 16;
  localparam int VF_PORCH  = 480;

  logic       VGA_clk      = 1'b0;
  logic       reset_n      = 1'b1;
  logic [9:0] xPixel       = '0;
  logic [9:0] yPixel       = '0;
  logic       display_area = 1'b0;
  logic       glyph_valid;
  logic [7:0] glyph_char;
  logic [3:0] glyph_row;
  logic [2:0] glyph_col;
  logic [2:0] glyph_slot;
  logic       pix_active;
  logic [7:0] frame_count;

  text_overlay_scheduler_if cfg_bus ();

  text_overlay_scheduler #(
    .NUM_SLOTS (NUM_SLOTS),
    .GLYPH_W   (GLYPH_W),
    .GLYPH_H   (GLYPH_H),
    .VF_PORCH  (VF_PORCH)
  ) dut (
    .VGA_clk      (VGA_clk),
    .reset_n      (reset_n),
    .xPixel       (xPixel),
    .yPixel       (yPixel),
    .display_area (display_area),
    .cfg          (cfg_bus),
    .glyph_valid  (glyph_valid),
    .glyph_char   (glyph_char),
    .glyph_row    (glyph_row),
    .glyph_col    (glyph_col),
    .glyph_slot   (glyph_slot),
    .pix_active   (pix_active),
    .frame_count  (frame_count)
  );

  always #5 VGA_clk = ~VGA_clk;

  typedef struct packed {
    logic       v;
    logic [7:0] ch;
    logic [3:0] row;
    logic [2:0] col;
    logic [2:0] slot;
    logic       act;
  } obs_t;

  obs_t  exp_q [$];
  obs_t  obs_q [$];
  string name_q [$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    exp_fc = 0;
  logic  tag_cur = 1'b0;
  logic  tag_d1  = 1'b0;
  logic  tag_d2  = 1'b0;

  // One clock: track which cycle's outputs belong to a tagged pixel and
  // capture them #1 after the edge.
  task automatic tick();
    obs_t o;
    @(posedge VGA_clk);
    tag_d2 = tag_d1;
    tag_d1 = tag_cur;
    #1;
    if (tag_d2) begin
      o.v = glyph_valid; o.ch = glyph_char; o.row = glyph_row;
      o.col = glyph_col; o.slot = glyph_slot; o.act = pix_active;
      obs_q.push_back(o);
    end
  endtask

  task automatic drive_pixel(input string nm, input int x, input int y, input logic disp,
                             input logic ev, input int ech, input int erow,
                             input int ecol, input int eslot);
    obs_t e;
    xPixel = 10'(x); yPixel = 10'(y); display_area = disp; tag_cur = 1'b1;
    e.v = ev; e.ch = 8'(ech); e.row = 4'(erow); e.col = 3'(ecol);
    e.slot = 3'(eslot); e.act = disp;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    tag_cur = 1'b0; xPixel = '0; yPixel = '0; display_area = 1'b0;
  endtask

  task automatic cfg_write(input int s, input int ch, input int x, input int y, input logic en);
    int guard = 0;
    cfg_bus.cfg_slot = 3'(s); cfg_bus.cfg_char = 8'(ch);
    cfg_bus.cfg_x = 10'(x); cfg_bus.cfg_y = 10'(y); cfg_bus.cfg_en = en;
    cfg_bus.cfg_valid = 1'b1;
    while (cfg_bus.cfg_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL cfg_write_timeout: cfg_ready=%b want 1", cfg_bus.cfg_ready);
    end else begin
      tick();
    end
    cfg_bus.cfg_valid = 1'b0;
  endtask

  // Crosses the commit point for exactly one cycle, then lets the copy happen.
  task automatic do_commit();
    xPixel = '0; yPixel = 10'(VF_PORCH); display_area = 1'b0;
    tick();
    xPixel = 10'd1;
    tick();
    xPixel = '0; yPixel = '0;
    exp_fc = (exp_fc + 1) % 256;
  endtask

  task automatic test_reset();
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_slot = '0; cfg_bus.cfg_char = '0;
    cfg_bus.cfg_x = '0; cfg_bus.cfg_y = '0; cfg_bus.cfg_en = 1'b0;
    display_area = 1'b1; xPixel = 10'd5;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({cfg_bus.cfg_ready, glyph_valid, glyph_char, glyph_row, glyph_col, glyph_slot, pix_active} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b char=%0d row=%0d col=%0d slot=%0d act=%b want all 0",
               cfg_bus.cfg_ready, glyph_valid, glyph_char, glyph_row, glyph_col, glyph_slot, pix_active);
    end
    n_cmp++;
    if (frame_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count);
    end
    reset_n = 1'b1; display_area = 1'b0; xPixel = '0;
    tick();
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset: got %b want 1", cfg_bus.cfg_ready);
    end
  endtask

  task automatic test_commit_delay();
    obs_t e, o; string nm;
    yPixel = 10'd100;
    cfg_write(0, 77, 200, 200, 1'b1);
    drive_pixel("m_before_commit", 203, 205, 1'b1, 1'b0, 0, 0, 0, 0);
    do_commit();
    n_cmp++;
    if (frame_count !== 8'(exp_fc)) begin
      n_bad++; $display("FAIL fc_first_commit: got %0d want %0d", frame_count, exp_fc);
    end
    drive_pixel("m_hit",    203, 205, 1'b1, 1'b1, 77, 5, 3, 0);
    drive_pixel("m_blank",  203, 205, 1'b0, 1'b0, 0, 0, 0, 0);
    drive_pixel("m_left",   199, 205, 1'b1, 1'b0, 0, 0, 0, 0);
    drive_pixel("m_corner", 207, 215, 1'b1, 1'b1, 77, 15, 7, 0);
    drive_pixel("m_right",  208, 205, 1'b1, 1'b0, 0, 0, 0, 0);
    drive_pixel("m_below",  200, 216, 1'b1, 1'b0, 0, 0, 0, 0);
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL %s: no output captured", nm);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL %s: got v%0d ch%0d r%0d c%0d s%0d a%0d want v%0d ch%0d r%0d c%0d s%0d a%0d",
                   nm, o.v, o.ch, o.row, o.col, o.slot, o.act, e.v, e.ch, e.row, e.col, e.slot, e.act);
        end
      end
    end
  endtask

  task automatic test_priority();
    obs_t e, o; string nm;
    cfg_write(0, 80, 100, 100, 1'b1);
    cfg_write(1, 81, 100, 100, 1'b1);
    do_commit();
    n_cmp++;
    if (frame_count !== 8'(exp_fc)) begin
      n_bad++; $display("FAIL fc_priority: got %0d want %0d", frame_count, exp_fc);
    end
    drive_pixel("prio_origin", 100, 100, 1'b1, 1'b1, 80, 0, 0, 0);
    drive_pixel("prio_corner", 107, 115, 1'b1, 1'b1, 80, 15, 7, 0);
    drive_pixel("prio_moved",  203, 205, 1'b1, 1'b0, 0, 0, 0, 0);
    cfg_write(0, 80, 100, 100, 1'b0);
    do_commit();
    drive_pixel("prio_slot1",  100, 100, 1'b1, 1'b1, 81, 0, 0, 1);
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL %s: no output captured", nm);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL %s: got v%0d ch%0d r%0d c%0d s%0d a%0d want v%0d ch%0d r%0d c%0d s%0d a%0d",
                   nm, o.v, o.ch, o.row, o.col, o.slot, o.act, e.v, e.ch, e.row, e.col, e.slot, e.act);
        end
      end
    end
  endtask

  task automatic test_last_write();
    obs_t e, o; string nm;
    cfg_write(2, 65, 300, 50, 1'b1);
    cfg_write(2, 66, 300, 50, 1'b1);
    cfg_write(5, 90, 400, 400, 1'b1);
    do_commit();
    n_cmp++;
    if (frame_count !== 8'(exp_fc)) begin
      n_bad++; $display("FAIL fc_last_write: got %0d want %0d", frame_count, exp_fc);
    end
    drive_pixel("lw_slot2",     301, 52,  1'b1, 1'b1, 66, 2, 1, 2);
    drive_pixel("lw_oob_slot",  400, 400, 1'b1, 1'b0, 0, 0, 0, 0);
    drive_pixel("lw_slot1_kept", 100, 100, 1'b1, 1'b1, 81, 0, 0, 1);
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL %s: no output captured", nm);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL %s: got v%0d ch%0d r%0d c%0d s%0d a%0d want v%0d ch%0d r%0d c%0d s%0d a%0d",
                   nm, o.v, o.ch, o.row, o.col, o.slot, o.act, e.v, e.ch, e.row, e.col, e.slot, e.act);
        end
      end
    end
  endtask

  task automatic test_wrap_edge();
    obs_t e, o; string nm;
    cfg_write(3, 69, 1020, 10, 1'b1);
    do_commit();
    drive_pixel("edge_x2",      2,    10, 1'b1, 1'b0, 0, 0, 0, 0);
    drive_pixel("edge_x1019",   1019, 10, 1'b1, 1'b0, 0, 0, 0, 0);
    drive_pixel("edge_x1023",   1023, 10, 1'b1, 1'b1, 69, 0, 3, 3);
    drive_pixel("edge_lastrow", 1023, 25, 1'b1, 1'b1, 69, 15, 3, 3);
    drive_pixel("edge_pastrow", 1023, 26, 1'b1, 1'b0, 0, 0, 0, 0);
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL %s: no output captured", nm);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL %s: got v%0d ch%0d r%0d c%0d s%0d a%0d want v%0d ch%0d r%0d c%0d s%0d a%0d",
                   nm, o.v, o.ch, o.row, o.col, o.slot, o.act, e.v, e.ch, e.row, e.col, e.slot, e.act);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o; string nm;
    int wch [4] = '{97, 98, 99, 100};
    int wx  [4] = '{500, 520, 540, 560};
    int k = 0, cyc = 0, lows = 0, low_at = -1;
    cfg_bus.cfg_valid = 1'b1;
    // Write 1 lands on the commit point; the copy cycle stalls write 2.
    while (k < 4 && cyc < 12) begin
      cfg_bus.cfg_slot = 3'(k); cfg_bus.cfg_char = 8'(wch[k]);
      cfg_bus.cfg_x = 10'(wx[k]); cfg_bus.cfg_y = 10'd300; cfg_bus.cfg_en = 1'b1;
      xPixel = (cyc == 1) ? 10'd0 : 10'd5;
      yPixel = 10'(VF_PORCH);
      if (cfg_bus.cfg_ready !== 1'b1) begin
        lows++; low_at = cyc;
      end else begin
        k++;
      end
      tick();
      cyc++;
    end
    cfg_bus.cfg_valid = 1'b0; xPixel = '0; yPixel = '0;
    exp_fc = (exp_fc + 1) % 256;
    n_cmp++;
    if (lows !== 1) begin
      n_bad++; $display("FAIL b2b_ready_low_cycles: got %0d want 1", lows);
    end
    n_cmp++;
    if (low_at !== 2) begin
      n_bad++; $display("FAIL b2b_ready_low_at: got cycle %0d want 2", low_at);
    end
    n_cmp++;
    if (cyc !== 5) begin
      n_bad++; $display("FAIL b2b_transfer_cycles: got %0d want 5", cyc);
    end
    n_cmp++;
    if (frame_count !== 8'(exp_fc)) begin
      n_bad++; $display("FAIL fc_b2b: got %0d want %0d", frame_count, exp_fc);
    end
    drive_pixel("b2b_w0",         500, 300, 1'b1, 1'b1, 97, 0, 0, 0);
    drive_pixel("b2b_w1_in",      520, 300, 1'b1, 1'b1, 98, 0, 0, 1);
    drive_pixel("b2b_w2_pending", 540, 300, 1'b1, 1'b0, 0, 0, 0, 0);
    drive_pixel("b2b_w3_pending", 560, 300, 1'b1, 1'b0, 0, 0, 0, 0);
    do_commit();
    drive_pixel("b2b_w2", 540, 300, 1'b1, 1'b1, 99, 0, 0, 2);
    drive_pixel("b2b_w3", 560, 300, 1'b1, 1'b1, 100, 0, 0, 3);
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL %s: no output captured", nm);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL %s: got v%0d ch%0d r%0d c%0d s%0d a%0d want v%0d ch%0d r%0d c%0d s%0d a%0d",
                   nm, o.v, o.ch, o.row, o.col, o.slot, o.act, e.v, e.ch, e.row, e.col, e.slot, e.act);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t e, o; string nm;
    cfg_write(0, 120, 600, 200, 1'b1);
    xPixel = 10'd500; yPixel = 10'd300; display_area = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (glyph_valid !== 1'b1 || glyph_char !== 8'd97) begin
      n_bad++; $display("FAIL pre_reset_glyph: got valid=%b char=%0d want valid=1 char=97", glyph_valid, glyph_char);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_bus.cfg_ready, glyph_valid, glyph_char, glyph_row, glyph_col, glyph_slot, pix_active} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b char=%0d row=%0d col=%0d slot=%0d act=%b want all 0",
               cfg_bus.cfg_ready, glyph_valid, glyph_char, glyph_row, glyph_col, glyph_slot, pix_active);
    end
    n_cmp++;
    if (frame_count !== 8'd0) begin
      n_bad++; $display("FAIL mid_reset_frame_count: got %0d want 0", frame_count);
    end
    repeat (2) tick();
    reset_n = 1'b1; display_area = 1'b0; xPixel = '0; yPixel = '0;
    exp_fc = 0;
    tick();
    do_commit();
    n_cmp++;
    if (frame_count !== 8'(exp_fc)) begin
      n_bad++; $display("FAIL fc_after_reset: got %0d want %0d", frame_count, exp_fc);
    end
    drive_pixel("rst_pending_gone", 600, 200, 1'b1, 1'b0, 0, 0, 0, 0);
    drive_pixel("rst_active_gone",  500, 300, 1'b1, 1'b0, 0, 0, 0, 0);
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL %s: no output captured", nm);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL %s: got v%0d ch%0d r%0d c%0d s%0d a%0d want v%0d ch%0d r%0d c%0d s%0d a%0d",
                   nm, o.v, o.ch, o.row, o.col, o.slot, o.act, e.v, e.ch, e.row, e.col, e.slot, e.act);
        end
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_commit_delay();
    test_priority();
    test_last_write();
    test_wrap_edge();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Time limit so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/text_overlay_scheduler.md
TEXT_OVERLAY_SCHEDULER -- requirements
Module: text_overlay_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of letter slots (1..8).
REQ-002 SHALL have parameter GLYPH_W, default 8, glyph width in pixels (power of 2).
REQ-003 SHALL have parameter GLYPH_H, default 16, glyph height in pixels (power of 2).
REQ-004 SHALL have parameter VF_PORCH, default 480, first non-visible row.
REQ-005 SHALL have port VGA_clk, input, 1, sole clock (25 MHz pixel clock).
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port xPixel, input, 10, current pixel column from timing generator.
REQ-008 SHALL have port yPixel, input, 10, current pixel row from timing generator.
REQ-009 SHALL have port display_area, input, 1, high while pixel is visible.
REQ-010 SHALL have port cfg_valid, input, 1, slot-write request.
REQ-011 SHALL have port cfg_ready, output, 1, slot-write accept; transfer when cfg_valid && cfg_ready.
REQ-012 SHALL have port cfg_slot, input, 3, slot index to write.
REQ-013 SHALL have port cfg_char, input, 8, character code (ASCII).
REQ-014 SHALL have ports cfg_x and cfg_y, input, 10 each, glyph top-left corner.
REQ-015 SHALL have port cfg_en, input, 1, slot enable.
REQ-016 SHALL have port glyph_valid, output, 1, pixel lies inside an enabled slot.
REQ-017 SHALL have port glyph_char, output, 8, character of winning slot.
REQ-018 SHALL have ports glyph_row (log2 GLYPH_H bits) and glyph_col (log2 GLYPH_W bits), output, offset within glyph.
REQ-019 SHALL have port glyph_slot, output, 3, index of winning slot.
REQ-020 SHALL have port pix_active, output, 1, display_area delayed to align with glyph outputs.
REQ-021 SHALL have port frame_count, output, 8, count of table commits.

Function
REQ-022 SHALL keep two slot tables: pending (written by cfg) and active (used for drawing).
REQ-023 SHALL write pending[cfg_slot] with {cfg_char, cfg_x, cfg_y, cfg_en} and set its dirty bit on each accepted transfer.
REQ-024 SHALL ignore accepted writes with cfg_slot >= NUM_SLOTS (no state change, transfer still completes).
REQ-025 SHALL apply last-write-wins when a slot is written more than once before commit.
REQ-026 SHALL detect commit point as the cycle with yPixel == VF_PORCH and xPixel == 0.
REQ-027 SHALL, on the cycle after commit point, copy every dirty pending slot to active, clear all dirty bits, and increment frame_count (wraps 255 -> 0).
REQ-028 SHALL drive cfg_ready low only during the commit-copy cycle; high otherwise after reset.
REQ-029 SHALL, for a write coinciding with commit point, accept it and include it in that commit.
REQ-030 SHALL declare slot hit when cfg_en set, xPixel - x in [0, GLYPH_W) and yPixel - y in [0, GLYPH_H), computed in 11 bits so glyphs near 1023 never wrap to column/row 0.
REQ-031 SHALL, on overlapping hits, select the lowest slot index.
REQ-032 SHALL pipeline in two stages: stage 1 registers per-slot hit and offsets; stage 2 registers priority selection to outputs.
REQ-033 SHALL produce outputs for pixel (x,y) sampled at cycle N exactly on cycle N+2; pix_active is display_area delayed 2 cycles.
REQ-034 SHALL drive glyph_valid low when no slot hits or display_area was low; glyph_char/row/col/slot then 0.

Reset
REQ-035 SHALL, while reset_n low, clear pending and active tables (all disabled, zero fields), dirty bits, and frame_count.
REQ-036 SHALL hold cfg_ready, glyph_valid, glyph_char, glyph_row, glyph_col, glyph_slot, pix_active at 0 during reset.
REQ-037 SHALL, on reset mid-frame or mid-commit, discard all pending writes; first commit after release increments frame_count to 1.

Verification
REQ-038 SHALL cover: write slot0 {'M',200,200,en} mid-frame -> no glyph_valid until after commit; next frame pixel (203,205) yields glyph_valid=1, char 77, col 3, row 5, two cycles later.
REQ-039 SHALL cover: slots 0 and 1 both at (100,100), pixel (100,100) -> glyph_slot 0.
REQ-040 SHALL cover: write slot2 twice ('A' then 'B') before commit -> active slot2 char 66; frame_count +1.
REQ-041 SHALL cover: slot at x=1020, pixel x=2 -> no hit; pixel x=1023 -> hit, col 3.
REQ-042 SHALL cover: cfg_valid held across commit point -> cfg_ready low exactly one cycle, no write lost or duplicated.
REQ-043 SHALL cover: reset_n pulsed low mid-frame with dirty slots -> all outputs 0 immediately, no glyph after next commit, frame_count=1.
